// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one word-bus access at a time, forms
// byte lanes for stores, extracts and extends load data, and flags misalignment/timeouts.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic        m_write,
    input  logic [1:0]  m_size,
    input  logic        m_sign,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_stall,
    output logic        m_done,
    output logic [31:0] m_rdata,
    output logic        m_misaligned,
    output logic        m_bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [1:0]  lo_r;
    logic [1:0]  size_r;
    logic        sign_r;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    // m_sign: 0 selects sign extension, 1 selects zero extension
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = sign ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = sign ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign m_stall = m_valid & ~m_done;

    // Access sequencer: IDLE -> REQ -> (RESP) -> DONE, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 16'd0;
            lo_r         <= 2'b00;
            size_r       <= 2'b00;
            sign_r       <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_wdata    <= 32'h0;
            bus_be       <= 4'h0;
            m_done       <= 1'b0;
            m_rdata      <= 32'h0;
            m_misaligned <= 1'b0;
            m_bus_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (m_valid) begin
                        if (is_misaligned(m_size, m_addr[1:0])) begin
                            state_r      <= DONE;
                            m_done       <= 1'b1;
                            m_misaligned <= 1'b1;
                            m_rdata      <= 32'h0;
                        end else begin
                            state_r   <= REQ;
                            cnt_r     <= 16'd0;
                            lo_r      <= m_addr[1:0];
                            size_r    <= m_size;
                            sign_r    <= m_sign;
                            bus_req   <= 1'b1;
                            bus_we    <= m_write;
                            bus_addr  <= {m_addr[31:2], 2'b00};
                            bus_be    <= lane_be(m_size, m_addr[1:0]);
                            bus_wdata <= lane_wdata(m_size, m_wdata);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt_r   <= cnt_r + 16'd1;
                        if (bus_we) begin
                            state_r <= DONE;
                            m_done  <= 1'b1;
                        end else begin
                            state_r <= RESP;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= DONE;
                        bus_req   <= 1'b0;
                        m_done    <= 1'b1;
                        m_bus_err <= 1'b1;
                        m_rdata   <= 32'h0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        state_r <= DONE;
                        m_done  <= 1'b1;
                        m_rdata <= load_extract(bus_rdata, lo_r, size_r, sign_r);
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= DONE;
                        m_done    <= 1'b1;
                        m_bus_err <= 1'b1;
                        m_rdata   <= 32'h0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    m_done       <= 1'b0;
                    m_misaligned <= 1'b0;
                    m_bus_err    <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    bus_req      <= 1'b0;
                    m_done       <= 1'b0;
                    m_misaligned <= 1'b0;
                    m_bus_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expected completions are queued at issue
// and popped when m_done pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_write = 1'b0;
    logic [1:0]  m_size = 2'b00;
    logic        m_sign = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_stall;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        m_misaligned;
    logic        m_bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_write(m_write), .m_size(m_size), .m_sign(m_sign),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_stall(m_stall), .m_done(m_done), .m_rdata(m_rdata),
        .m_misaligned(m_misaligned), .m_bus_err(m_bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_err);
        exp_t e;
        @(negedge clk);
        m_valid = 1'b1;
        m_write = w;
        m_size  = sz;
        m_sign  = sg;
        m_addr  = addr;
        m_wdata = wd;
        e.rdata = exp_rdata;
        e.mis   = exp_mis;
        e.err   = exp_err;
        sb.push_back(e);
    endtask

    task automatic check_bus(input string tag, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input logic we);
        @(negedge clk);
        chk({tag, "_req"}, bus_req, 1'b1);
        chk({tag, "_stall"}, m_stall, 1'b1);
        chk({tag, "_addr"}, bus_addr, addr);
        chk({tag, "_be"}, bus_be, be);
        chk({tag, "_we"}, bus_we, we);
        if (we) chk({tag, "_wdata"}, bus_wdata, wd);
    endtask

    task automatic grant(input string tag, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_req_hold"}, bus_req, 1'b1);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk({tag, "_req_drop"}, bus_req, 1'b0);
    endtask

    task automatic respond(input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
    endtask

    task automatic finish_access(input string tag, input int budget);
        exp_t e;
        for (int i = 0; i < budget && m_done !== 1'b1; i++) @(negedge clk);
        chk({tag, "_done"}, m_done, 1'b1);
        if (m_done === 1'b1) begin
            chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_rdata"}, m_rdata, e.rdata);
                chk({tag, "_mis"}, m_misaligned, e.mis);
                chk({tag, "_err"}, m_bus_err, e.err);
                chk({tag, "_stall_done"}, m_stall, 1'b0);
            end
        end
        m_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, m_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_req", bus_req, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_be", bus_be, 4'h0);
        chk("rst_addr", bus_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // byte store, gnt two cycles after request
        start(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
        check_bus("bst", 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b1);
        grant("bst", 2);
        finish_access("bst", 0);

        // half store upper lanes
        start(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 32'h0, 1'b0, 1'b0);
        check_bus("hst", 32'h0000_0010, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        grant("hst", 0);
        finish_access("hst", 0);

        // word store
        start(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        check_bus("wst", 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        grant("wst", 1);
        finish_access("wst", 0);

        // signed then unsigned byte load
        start(1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_bus("bld_s", 32'h0000_0200, 4'b0010, 32'h0, 1'b0);
        grant("bld_s", 0);
        chk("bld_s_nodone_resp", m_done, 1'b0);
        respond(1, 32'h1280_FF34);
        finish_access("bld_s", 4);

        start(1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0, 32'h0000_00FF, 1'b0, 1'b0);
        check_bus("bld_u", 32'h0000_0200, 4'b0010, 32'h0, 1'b0);
        grant("bld_u", 0);
        respond(0, 32'h1280_FF34);
        finish_access("bld_u", 4);

        // signed half load; rvalid in the grant cycle must be ignored
        start(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0);
        check_bus("hld_s", 32'h0000_0000, 4'b1100, 32'h0, 1'b0);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_5555;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("hld_s_gnt_rvalid_ignored", m_done, 1'b0);
        respond(0, 32'h8001_7FFF);
        finish_access("hld_s", 4);

        start(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h0000_8001, 1'b0, 1'b0);
        check_bus("hld_u", 32'h0000_0000, 4'b1100, 32'h0, 1'b0);
        grant("hld_u", 0);
        respond(0, 32'h8001_7FFF);
        finish_access("hld_u", 4);

        // misaligned word load: done with misaligned on the second cycle
        start(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_no_req", bus_req, 1'b0);
        finish_access("mis", 0);

        // timeout: granted load, rvalid never comes
        start(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b1);
        check_bus("tmo", 32'h0000_0040, 4'b1111, 32'h0, 1'b0);
        grant("tmo", 0);
        for (int i = 0; i < 2; i++) begin
            chk("tmo_not_early", m_done, 1'b0);
            @(negedge clk);
        end
        finish_access("tmo", 2);
        respond(0, 32'hCAFE_F00D);
        chk("tmo_stray_rvalid", m_done, 1'b0);
        chk("tmo_stray_req", bus_req, 1'b0);

        // normal word load after timeout
        start(1'b0, 2'b10, 1'b1, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0);
        check_bus("wld", 32'h0000_0044, 4'b1111, 32'h0, 1'b0);
        grant("wld", 0);
        respond(0, 32'h1357_9BDF);
        finish_access("wld", 4);

        // reset while waiting in RESP
        start(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b0, 1'b0);
        check_bus("rst_mid", 32'h0000_0080, 4'b1111, 32'h0, 1'b0);
        grant("rst_mid", 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", bus_req, 1'b0);
        chk("rst_mid_done", m_done, 1'b0);
        chk("rst_mid_addr", bus_addr, 32'h0);
        chk("rst_mid_rdata", m_rdata, 32'h0);
        sb.delete();
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        respond(0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_stray", m_done, 1'b0);
            @(negedge clk);
        end
        chk("rst_mid_idle_req", bus_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
